// File: rtl/cpu_pkg.sv
// Purpose: shared opcode encodings, sequencer state encoding and step width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int STEP_W = 2;

  // Opcode map, identical to the instruction decoder's encodings.
  localparam logic [3:0] OPC_NOP     = 4'b0000;
  localparam logic [3:0] OPC_LDI_A   = 4'b0001;
  localparam logic [3:0] OPC_LDI_B   = 4'b0010;
  localparam logic [3:0] OPC_LOAD_A  = 4'b0011;
  localparam logic [3:0] OPC_LOAD_B  = 4'b0100;
  localparam logic [3:0] OPC_STORE_A = 4'b0101;
  localparam logic [3:0] OPC_STORE_B = 4'b0110;
  localparam logic [3:0] OPC_ADD     = 4'b0111;
  localparam logic [3:0] OPC_SUB     = 4'b1000;
  localparam logic [3:0] OPC_JMP     = 4'b1001;
  localparam logic [3:0] OPC_JZ      = 4'b1010;
  localparam logic [3:0] OPC_JC      = 4'b1011;
  localparam logic [3:0] OPC_INC_A   = 4'b1100;
  localparam logic [3:0] OPC_DEC_A   = 4'b1101;

  // WAIT is only reachable when single-step support is compiled in.
  typedef enum logic [2:0] {
    F_ADDR  = 3'd0,
    F_READ  = 3'd1,
    F_LOAD  = 3'd2,
    EXECUTE = 3'd3,
    HALT    = 3'd4,
    WAIT    = 3'd5
  } state_t;

endpackage

// File: rtl/control_sequencer.sv
// Purpose: fetch/execute timing sequencer feeding the instruction decoder.
// Latency: instruction period = 3 fetch cycles + max(steps_required,1) execute cycles.
// Backpressure: halt parks the FSM before the next fetch; never stalls an instruction in flight.
//
// Ports:
//   clk, reset       - clock and synchronous active-high reset
//   halt             - level request to stop before the next fetch
//   step_req         - (CTRL_SINGLE_STEP_EN only) rising edge releases one instruction
//   opcode           - IR upper nibble, selects controller-owned MAR/RAM strobes in EXECUTE
//   steps_required   - execute length from decoder, re-evaluated every EXECUTE cycle
//   fetch_complete   - high in EXECUTE
//   step             - current execute step
//   pc_out_en, mar_load, ram_read, ir_load - bus strobes
//   instr_done       - pulse on the last execute step
//   halted           - high while parked (HALT, or WAIT in single-step builds)
//
// Optional feature macro: CTRL_SINGLE_STEP_EN.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              halt,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic              step_req,
`endif
  input  logic [3:0]        opcode,
  input  logic [STEP_W-1:0] steps_required,
  output logic              fetch_complete,
  output logic [STEP_W-1:0] step,
  output logic              pc_out_en,
  output logic              mar_load,
  output logic              ram_read,
  output logic              ir_load,
  output logic              instr_done,
  output logic              halted
);

  state_t            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [STEP_W-1:0] last_step;
  logic              is_last;
  logic              is_load, is_store;
  state_t            fetch_target;

`ifdef CTRL_SINGLE_STEP_EN
  logic step_req_q;
  logic step_rise;

  always_ff @(posedge clk) begin
    if (reset) step_req_q <= 1'b0;
    else       step_req_q <= step_req;
  end

  assign step_rise = step_req & ~step_req_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= F_ADDR;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // A zero step count still needs one execute cycle.
  assign last_step = (steps_required == '0) ? '0 : steps_required - STEP_W'(1);
  // ">=" rather than "==": if the decoder shrinks the count below the current
  // step, finish now instead of wrapping the counter mid-instruction.
  assign is_last   = (step_q >= last_step);
  assign is_load   = (opcode == OPC_LOAD_A)  || (opcode == OPC_LOAD_B);
  assign is_store  = (opcode == OPC_STORE_A) || (opcode == OPC_STORE_B);
  // halt is checked on the edge that would enter F_ADDR, so a halted machine
  // never shows fetch strobes.
  assign fetch_target = halt ? HALT : F_ADDR;

  always_comb begin
    state_d        = state_q;
    step_d         = '0;
    fetch_complete = 1'b0;
    pc_out_en      = 1'b0;
    mar_load       = 1'b0;
    ram_read       = 1'b0;
    ir_load        = 1'b0;
    instr_done     = 1'b0;
    halted         = 1'b0;

    case (state_q)
      F_ADDR: begin
        pc_out_en = 1'b1;
        mar_load  = 1'b1;
        state_d   = F_READ;
      end
      F_READ: begin
        ram_read = 1'b1;
        state_d  = F_LOAD;
      end
      F_LOAD: begin
        ram_read = 1'b1;
        ir_load  = 1'b1;
        state_d  = EXECUTE;
      end
      EXECUTE: begin
        fetch_complete = 1'b1;
        if (is_load) begin
          mar_load = (step_q == STEP_W'(0));
          ram_read = (step_q == STEP_W'(1)) || (step_q == STEP_W'(2));
        end else if (is_store) begin
          mar_load = (step_q == STEP_W'(0));
        end
        if (is_last) begin
          instr_done = 1'b1;
          step_d     = '0;
`ifdef CTRL_SINGLE_STEP_EN
          state_d    = WAIT;
`else
          state_d    = fetch_target;
`endif
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      HALT: begin
        halted = 1'b1;
        if (!halt) state_d = F_ADDR;
      end
`ifdef CTRL_SINGLE_STEP_EN
      WAIT: begin
        halted = 1'b1;
        if (step_rise) state_d = fetch_target;
      end
`endif
      default: state_d = F_ADDR;
    endcase
  end

  assign step = step_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Purpose: scoreboard bench for control_sequencer with directed instruction sequences.
// Latency: stimulus pushes the expected output set for each cycle; monitor checks it the same cycle.
// Backpressure: n/a.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       reset, halt, step_req;
  logic [3:0] opcode;
  logic [1:0] steps_required;
  logic       fetch_complete, pc_out_en, mar_load, ram_read, ir_load, instr_done, halted;
  logic [1:0] step;

  typedef struct packed {
    logic       halted;
    logic       done;
    logic       fc;
    logic [1:0] step;
    logic       pc;
    logic       mar;
    logic       rd;
    logic       ir;
  } exp_t;

  exp_t exp_q[$];
  int   cyc_q[$];
  int   tests  = 0;
  int   errors = 0;
  int   cyc_no = 0;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .halt           (halt),
`ifdef CTRL_SINGLE_STEP_EN
    .step_req       (step_req),
`endif
    .opcode         (opcode),
    .steps_required (steps_required),
    .fetch_complete (fetch_complete),
    .step           (step),
    .pc_out_en      (pc_out_en),
    .mar_load       (mar_load),
    .ram_read       (ram_read),
    .ir_load        (ir_load),
    .instr_done     (instr_done),
    .halted         (halted)
  );

  function automatic exp_t fa();
    exp_t e = '0; e.pc = 1'b1; e.mar = 1'b1; return e;
  endfunction
  function automatic exp_t fr();
    exp_t e = '0; e.rd = 1'b1; return e;
  endfunction
  function automatic exp_t fl();
    exp_t e = '0; e.rd = 1'b1; e.ir = 1'b1; return e;
  endfunction
  function automatic exp_t hl();
    exp_t e = '0; e.halted = 1'b1; return e;
  endfunction
  function automatic exp_t ex(input logic [1:0] s, input logic mar, input logic rd, input logic done);
    exp_t e = '0;
    e.fc = 1'b1; e.step = s; e.mar = mar; e.rd = rd; e.done = done;
    return e;
  endfunction

  // Drive this cycle's inputs just after the edge and queue the outputs expected in this cycle.
  task automatic cyc(input logic rst, input logic hlt, input logic [3:0] opc,
                     input logic [1:0] sr, input exp_t e);
    @(posedge clk);
    #1;
    reset          = rst;
    halt           = hlt;
    opcode         = opc;
    steps_required = sr;
    exp_q.push_back(e);
    cyc_q.push_back(cyc_no);
    cyc_no++;
  endtask

  // Monitor: pops and compares whenever an expectation is pending.
  initial begin
    exp_t act, e;
    int   c;
    forever begin
      @(negedge clk);
      act = {halted, instr_done, fetch_complete, step, pc_out_en, mar_load, ram_read, ir_load};
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        tests++;
        if (act !== e) begin
          errors++;
          $display("FAIL cycle%0d outputs: got halted=%b done=%b fc=%b step=%0d pc=%b mar=%b rd=%b ir=%b, want halted=%b done=%b fc=%b step=%0d pc=%b mar=%b rd=%b ir=%b",
                   c, act.halted, act.done, act.fc, act.step, act.pc, act.mar, act.rd, act.ir,
                   e.halted, e.done, e.fc, e.step, e.pc, e.mar, e.rd, e.ir);
        end
        tests++;
        if (pc_out_en === 1'b1 && ram_read === 1'b1) begin
          errors++;
          $display("FAIL cycle%0d bus_excl: got pc_out_en=1 ram_read=1, want at most one", c);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of stimulus, want finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; halt = 1'b0; step_req = 1'b0; opcode = 4'h0; steps_required = 2'd1;
    repeat (2) @(posedge clk);
    // NOP, 1 step (cycle 0 is also the post-reset state)
    cyc(0, 0, 4'h0, 2'd1, fa());
    cyc(0, 0, 4'h0, 2'd1, fr());
    cyc(0, 0, 4'h0, 2'd1, fl());
    cyc(0, 0, 4'h0, 2'd1, ex(0, 0, 0, 1));
    // LOAD_A, 3 steps
    cyc(0, 0, 4'h3, 2'd3, fa());
    cyc(0, 0, 4'h3, 2'd3, fr());
    cyc(0, 0, 4'h3, 2'd3, fl());
    cyc(0, 0, 4'h3, 2'd3, ex(0, 1, 0, 0));
    cyc(0, 0, 4'h3, 2'd3, ex(1, 0, 1, 0));
    cyc(0, 0, 4'h3, 2'd3, ex(2, 0, 1, 1));
    // STORE_B, 2 steps
    cyc(0, 0, 4'h6, 2'd2, fa());
    cyc(0, 0, 4'h6, 2'd2, fr());
    cyc(0, 0, 4'h6, 2'd2, fl());
    cyc(0, 0, 4'h6, 2'd2, ex(0, 1, 0, 0));
    cyc(0, 0, 4'h6, 2'd2, ex(1, 0, 0, 1));
    // JZ: decoder drops steps 2 -> 1 during step 0
    cyc(0, 0, 4'hA, 2'd2, fa());
    cyc(0, 0, 4'hA, 2'd2, fr());
    cyc(0, 0, 4'hA, 2'd2, fl());
    cyc(0, 0, 4'hA, 2'd1, ex(0, 0, 0, 1));
    // ADD with halt raised mid-execute
    cyc(0, 0, 4'h7, 2'd2, fa());
    cyc(0, 0, 4'h7, 2'd2, fr());
    cyc(0, 0, 4'h7, 2'd2, fl());
    cyc(0, 1, 4'h7, 2'd2, ex(0, 0, 0, 0));
    cyc(0, 1, 4'h7, 2'd2, ex(1, 0, 0, 1));
    cyc(0, 1, 4'h7, 2'd2, hl());
    cyc(0, 0, 4'h7, 2'd2, hl());
    // LOAD_A with reset in F_READ, then again at execute step 1
    cyc(0, 0, 4'h3, 2'd3, fa());
    cyc(1, 0, 4'h3, 2'd3, fr());
    cyc(0, 0, 4'h3, 2'd3, fa());
    cyc(0, 0, 4'h3, 2'd3, fr());
    cyc(0, 0, 4'h3, 2'd3, fl());
    cyc(0, 0, 4'h3, 2'd3, ex(0, 1, 0, 0));
    cyc(1, 0, 4'h3, 2'd3, ex(1, 0, 1, 0));
    // steps_required = 0 behaves as a single step
    cyc(0, 0, 4'h0, 2'd0, fa());
    cyc(0, 0, 4'h0, 2'd0, fr());
    cyc(0, 0, 4'h0, 2'd0, fl());
    cyc(0, 0, 4'h0, 2'd0, ex(0, 0, 0, 1));
    // LOAD_A whose count shrinks below the current step: finish, no wrap
    cyc(0, 0, 4'h3, 2'd3, fa());
    cyc(0, 0, 4'h3, 2'd3, fr());
    cyc(0, 0, 4'h3, 2'd3, fl());
    cyc(0, 0, 4'h3, 2'd3, ex(0, 1, 0, 0));
    cyc(0, 0, 4'h3, 2'd1, ex(1, 0, 1, 1));
    cyc(0, 0, 4'h0, 2'd1, fa());
    cyc(0, 0, 4'h0, 2'd1, fr());

    @(posedge clk);
    @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
